mem_arbiter_2to1: RTL and testbench
===================================

MEM_ARBITER_2TO1 -- requirements
Module: mem_arbiter_2to1

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning memory request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning one full cache line (4 blocks x 4 B) returned per memory response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-005 SHALL have ports r0_valid (input, 1), r0_addr (input, ADDR_WIDTH), r0_ready (output, 1), r0_rdata (output, DATA_WIDTH): requester 0, the instruction-cache refill port.
REQ-006 SHALL have ports r1_valid, r1_addr, r1_ready, r1_rdata with identical directions and widths: requester 1, the data / decompressor port.
REQ-007 SHALL have ports mem_valid (output, 1), mem_addr (output, ADDR_WIDTH), mem_ready (input, 1), mem_rdata (input, DATA_WIDTH): the shared memory port.
REQ-008 SHALL have port grant_id (output, 1): the requester owning the memory port; valid only while busy is 1.
REQ-009 SHALL have port busy (output, 1): a memory transaction is outstanding.
REQ-010 SHALL have ports r0_count and r1_count (outputs, 32 each): completed transactions per requester.

Function
REQ-011 Protocol, both sides: the requester holds valid and a stable addr until ready. ready is a one-cycle pulse with rdata valid in that same cycle. The requester drops valid in the cycle after ready.
REQ-012 FSM states: IDLE, BUSY, HOLD.
REQ-013 IDLE: if any rX_valid is 1, select a winner, latch its addr and id, and go to BUSY. Otherwise stay in IDLE.
REQ-014 Arbitration is round-robin. On a tie, the requester not granted last wins. last_grant updates at each grant.
REQ-015 Latency: valid sampled in IDLE at cycle t gives mem_valid=1 with the latched addr from cycle t+1.
REQ-016 BUSY: mem_valid=1 and mem_addr=latched address, both held stable. rX_addr changes after grant are ignored.
REQ-017 BUSY with mem_ready=1 at cycle k, same cycle:
  - r[grant]_ready=1 and r[grant]_rdata=mem_rdata, combinationally;
  - ready is suppressed if r[grant]_valid=0 (requester withdrew);
  - the other requester's ready stays 0.
REQ-018 After mem_ready at cycle k: mem_valid=0 from k+1, state HOLD at k+1, IDLE at k+2. The earliest next mem_valid is k+3.
REQ-019 HOLD ignores all rX_valid. This prevents re-granting a stale request still high for one cycle.
REQ-020 A requester that drops valid while BUSY does not abort the memory transaction. The arbiter completes it and discards the data.
REQ-021 mem_ready in IDLE or HOLD is ignored: no ready pulse, no state change.
REQ-022 Counter increment: on a delivered ready pulse, r[grant]_count increments by 1. Counters saturate at 32'hFFFF_FFFF. Suppressed completions (REQ-017) do not count.
REQ-023 busy=1 in BUSY only. grant_id holds the latched id.
REQ-024 rX_rdata SHALL be zero whenever rX_ready=0.

Reset
REQ-025 While reset=1 at a clock edge:
  - state returns to IDLE; mem_valid=0, busy=0, grant_id=0;
  - r0_count=0, r1_count=0;
  - last_grant=1, so requester 0 wins the first tie.
REQ-026 Reset asserted mid-BUSY abandons the transaction: mem_valid=0 from the next cycle, and no ready pulse is produced.
REQ-027 r0_ready and r1_ready SHALL be 0 during reset regardless of mem_ready.

Structure
REQ-028 A shared package holds the FSM state encoding (IDLE=2'd0, BUSY=2'd1, HOLD=2'd2) and the requester id constants REQ_ICACHE=0 and REQ_DATA=1.
REQ-029 One sub-module is natural: rr_pick2, the combinational round-robin selector. Inputs: two valids and last_grant. Outputs: grant_valid and grant_id.

Verification
REQ-030 Single request: r0_valid=1, r0_addr=32'h0000_0100 at t=0; memory responds at t=3 with 128'hA5...A5. Required: mem_valid 1 during t=1..3, mem_addr=32'h100, r0_ready=1 only at t=3 with rdata A5...A5, r0_count=1.
REQ-031 Simultaneous requests: r0 and r1 both valid at t=0 after reset. Required: r0 granted first; r1 granted at the first IDLE after r0 completes; order 0,1,0,1 under continuous contention.
REQ-032 Stale-valid guard: r0 keeps valid high one cycle past its ready. Required: no second grant to r0 in HOLD; r0_count increments by exactly 1.
REQ-033 Withdrawal: r1 drops valid while BUSY; mem_ready arrives two cycles later. Required: r1_ready stays 0, r1_count is unchanged, FSM returns to IDLE via HOLD.
REQ-034 Reset mid-transaction: reset=1 for one cycle while BUSY, with mem_ready=1 in that cycle. Required: no ready pulse to either requester, mem_valid=0 on the next cycle, counters 0, r0 wins the next tie.
REQ-035 Spurious mem_ready in IDLE. Required: no outputs change.

Source files
------------

// File: rtl/mem_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 memory arbiter: FSM encoding, requester ids
// and the saturating completion-counter helper.
package mem_arbiter_2to1_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } arb_state_t;

   localparam logic REQ_ICACHE = 1'b0;
   localparam logic REQ_DATA   = 1'b1;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mem_arbiter_2to1_rr_pick2.sv
// Combinational two-way round-robin selector: on a tie the requester that was
// not granted last wins.
module rr_pick2
   import mem_arbiter_2to1_pkg::*;
(
   input  logic valid0,
   input  logic valid1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   always_comb begin
      grant_valid = valid0 | valid1;
      grant_id    = REQ_ICACHE;
      if (valid0 && valid1) begin
         grant_id = ~last_grant;
      end else if (valid1) begin
         grant_id = REQ_DATA;
      end
   end

endmodule

// File: rtl/mem_arbiter_2to1.sv
// Two-requester memory arbiter: round-robin grant, one outstanding transaction,
// with a one-cycle HOLD after each completion to reject stale request valids.
module mem_arbiter_2to1
   import mem_arbiter_2to1_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  r0_valid,
   input  logic [ADDR_WIDTH-1:0] r0_addr,
   output logic                  r0_ready,
   output logic [DATA_WIDTH-1:0] r0_rdata,

   input  logic                  r1_valid,
   input  logic [ADDR_WIDTH-1:0] r1_addr,
   output logic                  r1_ready,
   output logic [DATA_WIDTH-1:0] r1_rdata,

   output logic                  mem_valid,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,

   output logic                  grant_id,
   output logic                  busy,
   output logic [31:0]           r0_count,
   output logic [31:0]           r1_count
);

   arb_state_t            state_q, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  id_q;
   logic                  last_q;
   logic [31:0]           cnt0_q, cnt1_q;

   logic pick_valid, pick_id;
   logic owner_valid, complete, deliver;

   rr_pick2 u_pick (
      .valid0      (r0_valid),
      .valid1      (r1_valid),
      .last_grant  (last_q),
      .grant_valid (pick_valid),
      .grant_id    (pick_id)
   );

   always_comb begin
      state_nxt = state_q;
      unique case (state_q)
         ST_IDLE: if (pick_valid) state_nxt = ST_BUSY;
         ST_BUSY: if (mem_ready)  state_nxt = ST_HOLD;
         ST_HOLD: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Completion still retires the transaction when the owner withdrew; only
   // the ready pulse (and its count) is suppressed.
   always_comb begin
      owner_valid = (id_q == REQ_DATA) ? r1_valid : r0_valid;
      complete    = (state_q == ST_BUSY) && mem_ready && !reset;
      deliver     = complete && owner_valid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         id_q    <= REQ_ICACHE;
         last_q  <= REQ_DATA;
         cnt0_q  <= '0;
         cnt1_q  <= '0;
      end else begin
         state_q <= state_nxt;
         if (state_q == ST_IDLE && pick_valid) begin
            addr_q <= (pick_id == REQ_DATA) ? r1_addr : r0_addr;
            id_q   <= pick_id;
            last_q <= pick_id;
         end
         if (deliver && id_q == REQ_ICACHE) cnt0_q <= sat_inc32(cnt0_q);
         if (deliver && id_q == REQ_DATA)   cnt1_q <= sat_inc32(cnt1_q);
      end
   end

   always_comb begin
      mem_valid = (state_q == ST_BUSY);
      busy      = (state_q == ST_BUSY);
      mem_addr  = addr_q;
      grant_id  = id_q;
      r0_count  = cnt0_q;
      r1_count  = cnt1_q;
      r0_ready  = deliver && (id_q == REQ_ICACHE);
      r1_ready  = deliver && (id_q == REQ_DATA);
      r0_rdata  = r0_ready ? mem_rdata : '0;
      r1_rdata  = r1_ready ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Self-checking bench for mem_arbiter_2to1: directed scenarios then random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_arbiter_2to1;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 128;

   logic          clk = 1'b0;
   logic          reset;
   logic          r0_valid, r1_valid, r0_ready, r1_ready;
   logic [AW-1:0] r0_addr, r1_addr, mem_addr;
   logic [DW-1:0] r0_rdata, r1_rdata, mem_rdata;
   logic          mem_valid, mem_ready, grant_id, busy;
   logic [31:0]   r0_count, r1_count;

   mem_arbiter_2to1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .r0_valid  (r0_valid),
      .r0_addr   (r0_addr),
      .r0_ready  (r0_ready),
      .r0_rdata  (r0_rdata),
      .r1_valid  (r1_valid),
      .r1_addr   (r1_addr),
      .r1_ready  (r1_ready),
      .r1_rdata  (r1_rdata),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .grant_id  (grant_id),
      .busy      (busy),
      .r0_count  (r0_count),
      .r1_count  (r1_count)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: one outstanding transaction plus a cooldown count of
   // cycles during which new requests are not considered.
   bit            m_pending;
   bit            m_owner;
   logic [AW-1:0] m_addr;
   int            m_cool;
   bit            m_last;
   logic [31:0]   m_cnt [2];

   logic          prev_busy = 1'b0;
   logic          q_grants [$];
   logic [31:0]   saved;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic          v [2];
      logic          deliver;
      bit            w;
      @(negedge clk);
      v[0] = r0_valid;
      v[1] = r1_valid;
      deliver = m_pending && mem_ready && !reset && v[m_owner];
      chk("mem_valid", mem_valid, m_pending);
      chk("busy", busy, m_pending);
      chk("grant_id", grant_id, m_owner);
      if (m_pending) chk("mem_addr", mem_addr, m_addr);
      chk("r0_ready", r0_ready, deliver && m_owner == 1'b0);
      chk("r1_ready", r1_ready, deliver && m_owner == 1'b1);
      chk("r0_rdata", r0_rdata, (deliver && m_owner == 1'b0) ? mem_rdata : '0);
      chk("r1_rdata", r1_rdata, (deliver && m_owner == 1'b1) ? mem_rdata : '0);
      chk("r0_count", r0_count, m_cnt[0]);
      chk("r1_count", r1_count, m_cnt[1]);
      if (busy && !prev_busy) q_grants.push_back(grant_id);
      prev_busy = busy;
      @(posedge clk);
      if (reset) begin
         m_pending = 0; m_cool = 0; m_owner = 0; m_last = 1;
         m_cnt[0] = '0; m_cnt[1] = '0;
      end else if (m_pending) begin
         if (mem_ready) begin
            m_pending = 0;
            m_cool    = 1;
            if (deliver)
               m_cnt[m_owner] = (m_cnt[m_owner] == 32'hFFFF_FFFF) ? m_cnt[m_owner]
                                                                   : m_cnt[m_owner] + 32'd1;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (v[0] || v[1]) begin
         if (v[0] && v[1]) w = !m_last;
         else              w = v[1];
         m_pending = 1;
         m_owner   = w;
         m_last    = w;
         m_addr    = w ? r1_addr : r0_addr;
      end
      #1;
   endtask

   initial begin
      logic exp_order [4];
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
      m_pending = 0; m_owner = 0; m_cool = 0; m_last = 1; m_addr = '0;
      m_cnt[0] = '0; m_cnt[1] = '0;
      reset = 1'b1; r0_valid = 0; r1_valid = 0; r0_addr = '0; r1_addr = '0;
      mem_ready = 0; mem_rdata = '0;
      repeat (3) cycle();
      reset = 1'b0;
      cycle();

      // single request, memory answers three cycles after the grant cycle
      r0_valid = 1; r0_addr = 32'h0000_0100;
      cycle(); cycle(); cycle();
      mem_ready = 1; mem_rdata = {16{8'hA5}};
      cycle();
      mem_ready = 0; mem_rdata = '0; r0_valid = 0;
      cycle(); cycle();
      chk("single_r0_count", r0_count, 32'd1);

      // continuous contention after reset
      reset = 1; cycle(); reset = 0;
      q_grants.delete();
      r0_valid = 1; r1_valid = 1; r0_addr = 32'h100; r1_addr = 32'h200;
      for (int i = 0; i < 12; i++) begin
         mem_ready = m_pending;
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end
      r0_valid = 0; r1_valid = 0; mem_ready = 0;
      repeat (3) cycle();
      for (int i = 0; i < 4; i++)
         chk("grant_order", (i < q_grants.size()) ? q_grants[i] : 1'bx, exp_order[i]);

      // stale valid held one cycle past ready
      q_grants.delete();
      saved = r0_count;
      r0_valid = 1; r0_addr = 32'h300;
      cycle();
      mem_ready = 1; mem_rdata = {4{32'hDEAD_BEEF}};
      cycle();
      mem_ready = 0;
      cycle();
      r0_valid = 0;
      cycle(); cycle();
      chk("stale_count", r0_count, saved + 32'd1);
      chk("stale_grants", q_grants.size(), 1);

      // withdrawal while busy
      saved = r1_count;
      r1_valid = 1; r1_addr = 32'h400;
      cycle(); cycle();
      r1_valid = 0;
      cycle(); cycle();
      mem_ready = 1; mem_rdata = {4{32'h1234_5678}};
      cycle();
      mem_ready = 0;
      cycle(); cycle();
      chk("withdraw_count", r1_count, saved);
      chk("withdraw_idle", busy, 1'b0);

      // reset mid-transaction with mem_ready in the same cycle
      r0_valid = 1; r0_addr = 32'h500;
      cycle(); cycle();
      reset = 1; mem_ready = 1; mem_rdata = {4{32'hCAFE_F00D}};
      cycle();
      reset = 0; mem_ready = 0; r1_valid = 1; r1_addr = 32'h600;
      cycle();
      chk("rst_tie_winner", grant_id, 1'b0);
      chk("rst_tie_busy", busy, 1'b1);
      chk("rst_r0_count", r0_count, 32'd0);
      chk("rst_r1_count", r1_count, 32'd0);
      mem_ready = 1;
      cycle();
      mem_ready = 0; r0_valid = 0; r1_valid = 0;
      repeat (3) cycle();

      // spurious mem_ready while idle
      saved = r0_count;
      mem_ready = 1;
      repeat (3) begin
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end
      mem_ready = 0;
      chk("spurious_busy", busy, 1'b0);
      chk("spurious_count", r0_count, saved);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         r0_valid  = ($urandom_range(0, 9) < 6);
         r1_valid  = ($urandom_range(0, 9) < 6);
         r0_addr   = $urandom;
         r1_addr   = $urandom;
         mem_ready = ($urandom_range(0, 9) < 4);
         mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
